// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding
// and the byte counts for the header and each data word.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    localparam logic [1:0] HDR_LAST_IDX  = 2'(HDR_BYTES - 1);
    localparam logic [1:0] WORD_LAST_IDX = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects accepted bytes MSB-first into a 32-bit word and pulses
// o_word_ready on the byte that completes it.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [1:0]  i_last_idx,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_idx <= 2'd0;
        end else if (i_accept) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Data path is not reset; the index alone decides when the word is valid.
    always_ff @(posedge clk) begin
        if (i_accept) begin
            r_word <= {r_word[23:0], i_byte};
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_accept && (r_idx == i_last_idx);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian image into instruction memory and
// holds the CPU until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic [31:0]      pc_start,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_count;
    logic [CNT_W-1:0] r_words;
    logic [CNT_W-1:0] w_words_inc;
    logic [31:0]      w_hdr_next;
    logic [31:0]      w_word;
    logic [1:0]       w_last_idx;
    logic             w_accept;
    logic             w_word_ready;
    logic             w_start_ok;

    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_hdr_next  = {r_count[23:0], in_data};
    assign w_words_inc = r_words + CNT_W'(1);
    assign w_last_idx  = (r_state == ST_HDR) ? HDR_LAST_IDX : WORD_LAST_IDX;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start_ok),
        .i_accept     (w_accept),
        .i_last_idx   (w_last_idx),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_words <= '0;
        end else if (r_state == ST_WRITE) begin
            r_words <= w_words_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && (r_state == ST_HDR)) begin
            r_count <= w_hdr_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        im_we    = 1'b0;
        im_wdata = '0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_HDR;
            end
            ST_HDR: begin
                in_ready = 1'b1;
                if (w_word_ready) begin
                    if (w_hdr_next == 32'd0)                w_next = ST_DONE;
                    else if (w_hdr_next > 32'(MAX_WORDS))   w_next = ST_ERR;
                    else                                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (w_word_ready) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                im_we    = 1'b1;
                im_wdata = w_word;
                if (32'(w_words_inc) == r_count) w_next = ST_DONE;
                else                             w_next = ST_DATA;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    done     = 1'b0;
                    cpu_hold = 1'b1;
                    w_next   = ST_HDR;
                end
            end
            ST_ERR: begin
                error = 1'b1;
                if (start) begin
                    error  = 1'b0;
                    w_next = ST_HDR;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Address wraps modulo 2^32 by construction of the 32-bit add.
    assign im_addr      = BASE_ADDR + (32'(r_words) << 2);
    assign pc_start     = BASE_ADDR;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as
// stimulus is driven and checked when the loader strobes im_we.
module tb_imem_loader;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          MAXW  = 4;
    localparam int          CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          im_we;
    logic [31:0]   im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic [31:0]   pc_start;
    logic          done;
    logic          error;
    logic [CW-1:0] words_loaded;

    int n_tot  = 0;
    int n_pass = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[$];

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .pc_start     (pc_start),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard side: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        logic [63:0] e;
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", im_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", im_addr, e[63:32]);
                chk("write_data", im_wdata, e[31:0]);
                chk("ready_in_write", 32'(in_ready), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("byte_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, output int first_waits);
        int wt;
        first_waits = 0;
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], wt);
            if (i == 3) first_waits = wt;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] words[$], input bit gaps);
        int wt;
        send_word(32'(words.size()), gaps, wt);
        for (int k = 0; k < words.size(); k++) begin
            exp_q.push_back({BASE + 32'(4 * k), words[k]});
            send_word(words[k], gaps, wt);
            if (!gaps && k > 0) chk("accept_after_write", 32'(wt), 32'd1);
        end
        repeat (2) @(negedge clk);
        chk("load_done", 32'(done), 32'd1);
        chk("load_hold", 32'(cpu_hold), 32'd0);
        chk("load_count", 32'(words_loaded), 32'(words.size()));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int wt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_addr", im_addr, BASE);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_count", 32'(words_loaded), 32'd0);
        chk("pc_start", pc_start, BASE);

        // Basic two-word load, back-to-back bytes
        pulse_start();
        chk("hdr_ready", 32'(in_ready), 32'd1);
        img = '{32'h2008_0005, 32'h0000_000C};
        load_image(img, 1'b0);

        // Zero-length image
        pulse_start();
        chk("restart_done_low", 32'(done), 32'd0);
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        send_word(32'd0, 1'b0, wt);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        chk("zero_ready", 32'(in_ready), 32'd0);
        chk("zero_count", 32'(words_loaded), 32'd0);

        // Oversize header
        pulse_start();
        send_word(32'd5, 1'b0, wt);
        chk("over_error", 32'(error), 32'd1);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        chk("over_ready", 32'(in_ready), 32'd0);
        chk("over_done", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        chk("over_count", 32'(words_loaded), 32'd0);

        // Leave ERR, then a gapped three-word load
        pulse_start();
        chk("err_cleared", 32'(error), 32'd0);
        chk("err_hold", 32'(cpu_hold), 32'd1);
        img = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h8C02_0004};
        load_image(img, 1'b1);

        // Reset after 6 of 12 bytes, then a clean reload
        pulse_start();
        send_word(32'd2, 1'b0, wt);
        send_byte(8'h20, wt);
        send_byte(8'h08, wt);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_count", 32'(words_loaded), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        pulse_start();
        img = '{32'h2008_0005, 32'h0000_000C};
        load_image(img, 1'b0);

        // Reload one word with stray start pulses during DATA
        pulse_start();
        chk("reload_done_low", 32'(done), 32'd0);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        send_word(32'd1, 1'b0, wt);
        exp_q.push_back({BASE, 32'h0800_0010});
        send_byte(8'h08, wt);
        send_byte(8'h00, wt);
        pulse_start();
        chk("start_ignored_ready", 32'(in_ready), 32'd1);
        chk("start_ignored_done", 32'(done), 32'd0);
        send_byte(8'h00, wt);
        pulse_start();
        send_byte(8'h10, wt);
        repeat (2) @(negedge clk);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_hold_low", 32'(cpu_hold), 32'd0);
        chk("reload_count", 32'(words_loaded), 32'd1);
        chk("reload_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory port; the pipeline only ever reads instruction memory.
- Accepts a big-endian byte stream over a valid/ready handshake and assembles 32-bit MIPS words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU (PC update and fetch) until the image is complete, then releases it and presents the start PC.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; also the start PC.
- MAX_WORDS, 1024: largest accepted image, in words.
- CNT_W, 16: width of the word counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a load.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  32  word-aligned byte address.
- im_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  when high, the PC must not advance; OR it into the existing stall.
- pc_start  out  32  constant BASE_ADDR.
- done  out  1  load completed; level signal.
- error  out  1  header count exceeded MAX_WORDS; level signal.
- words_loaded  out  CNT_W  number of words written so far.

Behaviour:
- Handshake: a byte transfers on a cycle where in_valid && in_ready.
- Stream format:
  - 4 header bytes: word count N, MSB first.
  - Then N words of 4 bytes each, MSB first, so the first byte lands in [31:24].
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- Reset (any state, mid-load included):
  - State goes to IDLE; all counters clear.
  - im_we=0, im_addr=BASE_ADDR, im_wdata=0, in_ready=0, done=0, error=0, words_loaded=0, cpu_hold=1.
  - Memory contents already written are not undone.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - start goes to HDR and clears the byte index and words_loaded.
- HDR:
  - in_ready=1; shift each accepted byte into the count register.
  - On the 4th byte:
    - N==0: go to DONE.
    - N>MAX_WORDS: go to ERR.
    - Otherwise: go to DATA.
- DATA:
  - in_ready=1; shift accepted bytes into the word register.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, im_we=1, im_addr=BASE_ADDR+4*words_loaded, im_wdata=assembled word.
  - words_loaded increments at the end of the cycle.
  - If the incremented value equals N, go to DONE; else go to DATA.
- Latency: 4th byte of word k accepted in cycle t produces im_we in cycle t+1; earliest next byte accept is t+2.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERR:
  - error=1, cpu_hold=1, in_ready=0.
  - No memory writes occur for that load.
- start handling:
  - Ignored in HDR, DATA and WRITE.
  - In DONE or ERR, start clears done/error, re-asserts cpu_hold and goes to HDR.
- in_valid stalls:
  - The loader waits indefinitely with state and partial bytes preserved.
  - No timeout.
- Byte index is 2 bits and wraps 3→0 on accept.
- Address arithmetic is 32-bit modulo 2^32; no check against the instruction-memory size beyond MAX_WORDS.
- in_data is sampled only on transfer cycles; bytes with in_ready=0 are not consumed (the source holds them).

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE..ERR, 3 bits);
  - the header length constant HDR_BYTES=4;
  - WORD_BYTES=4.
- One sub-module, byte_packer: 2-bit index plus 32-bit MSB-first shift register, with a word_ready pulse and a clear.
- The FSM, counters and address generation stay in imem_loader.

Test Plan:
- Basic load: rst, start, stream 00 00 00 02, 20 08 00 05, 00 00 00 0C.
  - im_we twice: addr 0x0 data 0x20080005, then addr 0x4 data 0x0000000C.
  - done=1, cpu_hold=0, words_loaded=2.
- Zero count: header 00 00 00 00 → DONE one cycle after the 4th byte, no im_we, cpu_hold=0.
- Oversize: MAX_WORDS=4, header 00 00 00 05 → error=1, cpu_hold=1, in_ready=0, no im_we.
- Backpressure/gaps: random in_valid gaps inside a word.
  - Same words written as with no gaps.
  - in_ready=0 in every WRITE cycle.
  - A byte presented during WRITE is accepted the following cycle.
- Reset mid-load: rst after 6 of 12 bytes → IDLE, cpu_hold=1, words_loaded=0; a fresh start plus the full stream writes correctly.
- Reload: after DONE, start plus a 1-word image 0x0800_0010 → done drops, cpu_hold rises, write at BASE_ADDR, done again; start pulses during DATA are ignored.
